// File: rtl/image_core_scheduler_pkg.sv
// Shared types for the image core scheduler: instruction/pixel formats,
// scheduler states and the round-robin pick helper.
package image_core_scheduler_pkg;

  typedef enum logic [2:0] {
    OP_NOP,
    OP_ADD,
    OP_SUB,
    OP_AVG
  } opcode_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  localparam int unsigned MATRIX_CELLS = 4;

  typedef pixel_t [MATRIX_CELLS-1:0] pixelMatrix_t;

  typedef struct packed {
    opcode_t      op;
    pixelMatrix_t cellA;
    pixelMatrix_t cellB;
  } instruction_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } sched_state_t;

  localparam int unsigned MAX_REQ   = 32;
  localparam int unsigned MAX_REQ_W = $clog2(MAX_REQ);

  // First set bit of valid[n-1:0] at or above ptr, wrapping; ptr when none set.
  function automatic int unsigned rr_pick(input logic [MAX_REQ-1:0] valid,
                                          input int unsigned        ptr,
                                          input int unsigned        n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = ptr + k;
        if (idx >= n) idx = idx - n;
        if (valid[idx[MAX_REQ_W-1:0]] && !found) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/image_core_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant plus index, searching
// upward from rr_ptr with wrap.
module rr_arbiter
  import image_core_scheduler_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]         req_valid,
  input  logic [$clog2(N)-1:0] rr_ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_idx,
  output logic                 grant_valid
);
  localparam int unsigned IW = $clog2(N);

  logic [MAX_REQ-1:0] valid_ext;
  int unsigned        pick;

  always_comb begin
    valid_ext          = '0;
    valid_ext[N-1:0]   = req_valid;
    pick               = rr_pick(valid_ext, 32'(rr_ptr), N);
    grant_idx          = IW'(pick);
    grant_valid        = |req_valid;
    grant              = '0;
    if (grant_valid) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/image_core_scheduler.sv
// Shares one image processing core between NUM_REQ requesters, one
// instruction in flight, round-robin grant, result returned with requester ID.
module image_core_scheduler
  import image_core_scheduler_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 2,
  parameter int unsigned CORE_LATENCY = 1
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  instruction_t               req_iw [NUM_REQ],
  output instruction_t               core_iw,
  input  pixelMatrix_t               core_result,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0] rsp_id,
  output pixelMatrix_t               rsp_result,
  output logic                       busy
);
  localparam int unsigned IDW = $clog2(NUM_REQ);
  localparam int unsigned CW  = $clog2(CORE_LATENCY + 1);

  sched_state_t   state_q, state_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  instruction_t   core_iw_q, core_iw_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  pixelMatrix_t   rsp_result_q, rsp_result_d;

  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_idx;
  logic               grant_valid;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req_valid   (req_valid),
    .rr_ptr      (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  // Grant is only offered in IDLE, so any valid grant there is a transfer.
  assign req_ready  = (state_q == IDLE) ? grant : '0;
  assign busy       = (state_q != IDLE);
  assign core_iw    = core_iw_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_result = rsp_result_q;

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    cnt_d        = cnt_q;
    core_iw_d    = core_iw_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    case (state_q)
      IDLE: begin
        if (grant_valid) begin
          core_iw_d = req_iw[grant_idx];
          rsp_id_d  = grant_idx;
          rr_ptr_d  = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + IDW'(1);
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = CW'(CORE_LATENCY - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_result_d = core_result;
          rsp_valid_d  = 1'b1;
          state_d      = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      cnt_q        <= '0;
      core_iw_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_result_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      cnt_q        <= cnt_d;
      core_iw_q    <= core_iw_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
    end
  end

endmodule

// File: tb/tb_image_core_scheduler.sv
// Directed bench for image_core_scheduler: two instances (core latency 1 and 3)
// each driving a small behavioural core model.
module tb_image_core_scheduler;
  import image_core_scheduler_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [1:0]   req_valid0, req_ready0;
  instruction_t req_iw0 [2];
  instruction_t core_iw0;
  pixelMatrix_t core_result0, rsp_result0;
  logic         rsp_valid0, rsp_ready0, rsp_id0, busy0;

  logic [1:0]   req_valid1, req_ready1;
  instruction_t req_iw1 [2];
  instruction_t core_iw1;
  pixelMatrix_t core_result1, rsp_result1;
  logic         rsp_valid1, rsp_ready1, rsp_id1, busy1;

  image_core_scheduler #(.NUM_REQ(2), .CORE_LATENCY(1)) u0 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid0), .req_ready(req_ready0),
    .req_iw(req_iw0), .core_iw(core_iw0), .core_result(core_result0),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready0), .rsp_id(rsp_id0),
    .rsp_result(rsp_result0), .busy(busy0)
  );

  image_core_scheduler #(.NUM_REQ(2), .CORE_LATENCY(3)) u1 (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_iw(req_iw1), .core_iw(core_iw1), .core_result(core_result1),
    .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_id(rsp_id1),
    .rsp_result(rsp_result1), .busy(busy1)
  );

  function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  function automatic pixelMatrix_t core_fn(input instruction_t iw);
    pixelMatrix_t m;
    m = iw.cellA;
    if (iw.op == OP_ADD) begin
      for (int i = 0; i < 4; i++) begin
        m[i].r = sat_add(iw.cellA[i].r, iw.cellB[i].r);
        m[i].g = sat_add(iw.cellA[i].g, iw.cellB[i].g);
        m[i].b = sat_add(iw.cellA[i].b, iw.cellB[i].b);
      end
    end
    return m;
  endfunction

  // Core models: result valid CORE_LATENCY clocks after core_iw changes.
  pixelMatrix_t p0;
  pixelMatrix_t p1 [3];
  always @(posedge clk) begin
    p0    <= core_fn(core_iw0);
    p1[0] <= core_fn(core_iw1);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end
  assign core_result0 = p0;
  assign core_result1 = p1[2];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  pixelMatrix_t LIME, BLACK, R1, R2, R3;
  instruction_t iw_bl, iw_r12, iw_ll;

  // Precondition: u0 in IDLE, #1 after a posedge, request inputs already set.
  task automatic op0(input string tag, input logic [1:0] exp_grant,
                     input logic exp_id, input pixelMatrix_t exp_res);
    int n;
    #1;
    check($sformatf("%s_grant", tag), 256'(req_ready0), 256'(exp_grant));
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rsp_valid0 && n < 20);
    check($sformatf("%s_latency", tag), 256'(n), 256'(3));
    check($sformatf("%s_id", tag), 256'(rsp_id0), 256'(exp_id));
    check($sformatf("%s_result", tag), 256'(rsp_result0), 256'(exp_res));
    rsp_ready0 = 1'b1;
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    check($sformatf("%s_rsp_clear", tag), 256'(rsp_valid0), 256'(0));
    check($sformatf("%s_idle", tag), 256'(busy0), 256'(0));
  endtask

  logic seen;
  logic stable;
  int   n;

  initial begin
    LIME  = {4{24'h00FF00}};
    BLACK = '0;
    R1    = {4{24'h010000}};
    R2    = {4{24'h020000}};
    R3    = {4{24'h030000}};
    iw_bl  = '{op: OP_ADD, cellA: BLACK, cellB: LIME};
    iw_r12 = '{op: OP_ADD, cellA: R1, cellB: R2};
    iw_ll  = '{op: OP_ADD, cellA: LIME, cellB: LIME};

    reset_n = 1'b1;
    req_valid0 = '0; rsp_ready0 = 1'b0; req_iw0[0] = iw_bl; req_iw0[1] = iw_r12;
    req_valid1 = '0; rsp_ready1 = 1'b0; req_iw1[0] = iw_ll; req_iw1[1] = iw_ll;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_rsp_valid", 256'(rsp_valid0), 256'(0));
    check("rst_rsp_id", 256'(rsp_id0), 256'(0));
    check("rst_rsp_result", 256'(rsp_result0), 256'(0));
    check("rst_core_iw", 256'(core_iw0), 256'(0));
    check("rst_core_iw1", 256'(core_iw1), 256'(0));
    check("rst_busy", 256'(busy0), 256'(0));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reset in the middle of an operation
    req_valid0 = 2'b01;
    #1 check("abort_grant", 256'(req_ready0), 256'(2'b01));
    @(posedge clk); #1;
    req_valid0 = '0;
    check("abort_busy", 256'(busy0), 256'(1));
    @(posedge clk); #1;
    check("abort_in_wait", 256'(rsp_valid0), 256'(0));
    reset_n = 1'b0;
    #1;
    check("abort_rsp_valid", 256'(rsp_valid0), 256'(0));
    check("abort_busy_rst", 256'(busy0), 256'(0));
    check("abort_core_iw", 256'(core_iw0), 256'(0));
    check("abort_rsp_id", 256'(rsp_id0), 256'(0));
    check("abort_rr_ptr", 256'(u0.rr_ptr_q), 256'(0));
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen = seen | rsp_valid0;
    end
    check("abort_no_rsp", 256'(seen), 256'(0));

    // Single op from requester 0: black + lime
    req_valid0 = 2'b01;
    op0("single", 2'b01, 1'b0, LIME);
    req_valid0 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("single_core_iw_hold", 256'(core_iw0), 256'(iw_bl));
    check("single_rr_ptr", 256'(u0.rr_ptr_q), 256'(1));

    // Idle pointer: nothing requested, pointer unchanged
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      seen = seen | busy0 | (|req_ready0);
    end
    check("idle_quiet", 256'(seen), 256'(0));
    check("idle_rr_ptr", 256'(u0.rr_ptr_q), 256'(1));
    req_valid0 = 2'b10;
    op0("idle_req1", 2'b10, 1'b1, R3);
    req_valid0 = '0;
    check("idle_rr_ptr_wrap", 256'(u0.rr_ptr_q), 256'(0));

    // Contention: both valid continuously
    req_valid0 = 2'b11;
    for (int i = 0; i < 4; i++) begin
      if (i % 2 == 0) op0($sformatf("cont%0d", i), 2'b01, 1'b0, LIME);
      else            op0($sformatf("cont%0d", i), 2'b10, 1'b1, R3);
    end
    req_valid0 = '0;

    // Backpressure: consumer stalls for 5 clocks
    req_valid0 = 2'b11;
    #1 check("bp_grant", 256'(req_ready0), 256'(2'b01));
    n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (!rsp_valid0 && n < 20);
    check("bp_latency", 256'(n), 256'(3));
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check($sformatf("bp_valid%0d", i), 256'(rsp_valid0), 256'(1));
      check($sformatf("bp_id%0d", i), 256'(rsp_id0), 256'(0));
      check($sformatf("bp_result%0d", i), 256'(rsp_result0), 256'(LIME));
      check($sformatf("bp_ready%0d", i), 256'(req_ready0), 256'(0));
    end
    rsp_ready0 = 1'b1;
    #1 check("bp_no_same_cycle", 256'(req_ready0), 256'(0));
    @(posedge clk); #1;
    rsp_ready0 = 1'b0;
    check("bp_rsp_clear", 256'(rsp_valid0), 256'(0));
    check("bp_regrant", 256'(req_ready0), 256'(2'b10));
    req_valid0 = '0;

    // Latency 3 instance: lime + lime
    req_valid1 = 2'b01;
    #1 check("lat3_grant", 256'(req_ready1), 256'(2'b01));
    n = 0;
    stable = 1'b1;
    do begin
      @(posedge clk); #1; n++;
      if (n == 1) req_valid1 = '0;
      stable = stable & (core_iw1 === iw_ll);
    end while (!rsp_valid1 && n < 20);
    check("lat3_latency", 256'(n), 256'(5));
    check("lat3_result", 256'(rsp_result1), 256'(LIME));
    check("lat3_id", 256'(rsp_id1), 256'(0));
    check("lat3_core_iw_stable", 256'(stable), 256'(1));
    rsp_ready1 = 1'b1;
    @(posedge clk); #1;
    rsp_ready1 = 1'b0;
    check("lat3_rsp_clear", 256'(rsp_valid1), 256'(0));
    check("lat3_core_iw_hold", 256'(core_iw1), 256'(iw_ll));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
